uc_recovery_sequencer: RTL and testbench

Recovery controller for the dual-microcontroller monitor.
- Consumes the per-uC watchdog error levels and arbitrates which uC is the selected (active) processor.
- Sequences timed reset pulses and boot windows for faulted uCs through one shared timer, one recovery at a time.
- Locks out a uC that fails MAX_RETRIES consecutive recoveries.
- Sits between the two watchdog instances and the uC reset pins and select line in the monitor top level.

---
 rtl/uc_recovery_sequencer.sv | 140 ++++++++++++++
 tb/tb_uc_recovery_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uc_recovery_sequencer.sv
// Recovery sequencer for the dual-uC monitor: arbitrates the active uC and runs
// timed reset pulses plus boot windows for faulted uCs through one shared timer.
module uc_recovery_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES = 4096,
  parameter int unsigned BOOT_WAIT_CYCLES = 500000,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned CNT_W            = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic err_uc1,
  input  logic err_uc2,
  input  logic clr_lockout,
  output logic reset_uc1,
  output logic reset_uc2,
  output logic selected_uc,
  output logic none_ok,
  output logic lockout_uc1,
  output logic lockout_uc2,
  output logic busy
);

  localparam int unsigned RETRY_W = 3;
  localparam logic [CNT_W-1:0]   PULSE_LOAD = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BOOT_LOAD  = CNT_W'(BOOT_WAIT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [1:0] {IDLE, RST_PULSE, BOOT_WAIT} seqState_t;

  seqState_t state, stateNext;
  logic [CNT_W-1:0] timer, timerNext;
  logic target, targetNext;              // 0 = uC1, 1 = uC2
  logic [1:0] pend, pendNext;            // bit 0 = uC1, bit 1 = uC2
  logic [1:0] lockout, lockoutNext;
  logic [1:0][RETRY_W-1:0] retry, retryNext;
  logic selNext, noneOkNext, busyNext;
  logic [1:0] resetNext;
  logic [1:0] err, onTarget, healthy;

  // Next-state, status and output decode
  always_comb begin
    err         = {err_uc2, err_uc1};
    onTarget    = {(state != IDLE) & target, (state != IDLE) & ~target};
    healthy     = ~err & ~pend & ~lockout & ~onTarget;
    stateNext   = state;
    timerNext   = timer;
    targetNext  = target;
    pendNext    = pend | (err & ~lockout & ~onTarget);
    retryNext   = retry;
    lockoutNext = lockout;

    case (state)
      IDLE: begin
        if (pend[0] || pend[1]) begin
          if (pend[0]) begin
            targetNext  = 1'b0;
            pendNext[0] = 1'b0;
          end else begin
            targetNext  = 1'b1;
            pendNext[1] = 1'b0;
          end
          timerNext = PULSE_LOAD;
          stateNext = RST_PULSE;
        end
      end
      RST_PULSE: begin
        if (timer == '0) begin
          timerNext = BOOT_LOAD;
          stateNext = BOOT_WAIT;
        end else begin
          timerNext = timer - CNT_W'(1);
        end
      end
      BOOT_WAIT: begin
        if (timer == '0) begin
          stateNext = IDLE;
          if (!err[target]) begin
            retryNext[target] = '0;
          end else begin
            retryNext[target] = retry[target] + RETRY_W'(1);
            // A failed boot that has not exhausted its retries re-queues itself
            if (retryNext[target] == RETRY_MAX) lockoutNext[target] = 1'b1;
            else pendNext[target] = 1'b1;
          end
        end else begin
          timerNext = timer - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    if (clr_lockout) begin
      lockoutNext = '0;
      retryNext   = '0;
    end

    // Sticky selection: only move away from an unhealthy uC to a healthy one
    selNext = selected_uc;
    if (!healthy[selected_uc] && healthy[~selected_uc]) selNext = ~selected_uc;
    noneOkNext = ~healthy[selNext];

    busyNext  = (stateNext != IDLE);
    resetNext = lockoutNext |
                {(stateNext == RST_PULSE) & targetNext, (stateNext == RST_PULSE) & ~targetNext};
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      target      <= 1'b0;
      pend        <= '0;
      retry       <= '0;
      lockout     <= '0;
      selected_uc <= 1'b0;
      none_ok     <= 1'b0;
      busy        <= 1'b0;
      reset_uc1   <= 1'b0;
      reset_uc2   <= 1'b0;
      lockout_uc1 <= 1'b0;
      lockout_uc2 <= 1'b0;
    end else begin
      state       <= stateNext;
      timer       <= timerNext;
      target      <= targetNext;
      pend        <= pendNext;
      retry       <= retryNext;
      lockout     <= lockoutNext;
      selected_uc <= selNext;
      none_ok     <= noneOkNext;
      busy        <= busyNext;
      reset_uc1   <= resetNext[0];
      reset_uc2   <= resetNext[1];
      lockout_uc1 <= lockoutNext[0];
      lockout_uc2 <= lockoutNext[1];
    end
  end

endmodule

// File: tb/tb_uc_recovery_sequencer.sv
// Directed bench for uc_recovery_sequencer with pulse 4, boot window 10, 2 retries.
module tb_uc_recovery_sequencer;

  logic clk = 1'b0;
  logic reset, err_uc1, err_uc2, clr_lockout;
  logic reset_uc1, reset_uc2, selected_uc, none_ok, lockout_uc1, lockout_uc2, busy;
  logic [6:0] outs;

  int nChecks = 0;
  int nErrors = 0;

  uc_recovery_sequencer #(
    .RST_PULSE_CYCLES(4),
    .BOOT_WAIT_CYCLES(10),
    .MAX_RETRIES(2),
    .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .err_uc1(err_uc1), .err_uc2(err_uc2),
    .clr_lockout(clr_lockout), .reset_uc1(reset_uc1), .reset_uc2(reset_uc2),
    .selected_uc(selected_uc), .none_ok(none_ok), .lockout_uc1(lockout_uc1),
    .lockout_uc2(lockout_uc2), .busy(busy)
  );

  always #5 clk = ~clk;

  assign outs = {reset_uc1, reset_uc2, selected_uc, none_ok, lockout_uc1, lockout_uc2, busy};

  task automatic checkEq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic inRange(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, confirm the cleared outputs, then release
  task automatic doReset();
    reset = 1'b0; err_uc1 = 1'b0; err_uc2 = 1'b0; clr_lockout = 1'b0;
    step();
    step();
    checkEq("reset_outs", outs, 7'(0));
    reset = 1'b1;
  endtask

  initial begin
    // Idle with no errors
    doReset();
    for (int k = 1; k <= 20; k++) begin
      step();
      checkEq($sformatf("t1_outs@%0d", k), outs, 7'(0));
    end

    // Single successful recovery of uC1
    doReset();
    err_uc1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      checkEq($sformatf("t2_rst1@%0d", k), 7'(reset_uc1), 7'(inRange(k, 2, 5)));
      checkEq($sformatf("t2_busy@%0d", k), 7'(busy), 7'(inRange(k, 2, 15)));
      checkEq($sformatf("t2_sel@%0d", k), 7'(selected_uc), 7'(1));
      checkEq($sformatf("t2_nok@%0d", k), 7'(none_ok), 7'(0));
      checkEq($sformatf("t2_rst2@%0d", k), 7'(reset_uc2), 7'(0));
      if (k == 3) err_uc1 = 1'b0;
    end

    // Persistent uC1 error: two recoveries, lockout, then clear
    doReset();
    err_uc1 = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      checkEq($sformatf("t3_rst1@%0d", k), 7'(reset_uc1),
              7'(inRange(k, 2, 5) || inRange(k, 17, 20) || k >= 31));
      checkEq($sformatf("t3_busy@%0d", k), 7'(busy), 7'(inRange(k, 2, 15) || inRange(k, 17, 30)));
      checkEq($sformatf("t3_lock1@%0d", k), 7'(lockout_uc1), 7'(k >= 31));
      checkEq($sformatf("t3_sel@%0d", k), 7'(selected_uc), 7'(1));
    end
    clr_lockout = 1'b1;
    step();
    clr_lockout = 1'b0;
    checkEq("t3_clr_lock1", 7'(lockout_uc1), 7'(0));
    checkEq("t3_clr_rst1", 7'(reset_uc1), 7'(0));
    step();
    checkEq("t3_repend_rst1", 7'(reset_uc1), 7'(0));
    checkEq("t3_repend_busy", 7'(busy), 7'(0));
    step();
    checkEq("t3_restart_rst1", 7'(reset_uc1), 7'(1));
    checkEq("t3_restart_busy", 7'(busy), 7'(1));

    // Both errors on the same edge: uC1 first, uC2 right after
    doReset();
    err_uc1 = 1'b1;
    err_uc2 = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      checkEq($sformatf("t4_rst1@%0d", k), 7'(reset_uc1), 7'(inRange(k, 2, 5)));
      checkEq($sformatf("t4_rst2@%0d", k), 7'(reset_uc2), 7'(inRange(k, 17, 20)));
      checkEq($sformatf("t4_busy@%0d", k), 7'(busy), 7'(inRange(k, 2, 15) || inRange(k, 17, 30)));
      checkEq($sformatf("t4_sel@%0d", k), 7'(selected_uc), 7'(0));
      checkEq($sformatf("t4_nok@%0d", k), 7'(none_ok), 7'(inRange(k, 1, 16)));
      if (k == 3) begin
        err_uc1 = 1'b0;
        err_uc2 = 1'b0;
      end
    end

    // uC2 faults while uC1 is in its reset pulse
    doReset();
    err_uc1 = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      checkEq($sformatf("t5_rst1@%0d", k), 7'(reset_uc1), 7'(inRange(k, 2, 5)));
      checkEq($sformatf("t5_rst2@%0d", k), 7'(reset_uc2), 7'(inRange(k, 17, 20)));
      checkEq($sformatf("t5_busy@%0d", k), 7'(busy), 7'(inRange(k, 2, 15) || inRange(k, 17, 30)));
      checkEq($sformatf("t5_sel@%0d", k), 7'(selected_uc), 7'(inRange(k, 1, 16)));
      checkEq($sformatf("t5_nok@%0d", k), 7'(none_ok), 7'(inRange(k, 4, 16)));
      if (k == 3) begin
        err_uc1 = 1'b0;
        err_uc2 = 1'b1;
      end
      if (k == 4) err_uc2 = 1'b0;
    end

    // Reset asserted in the middle of a reset pulse
    doReset();
    err_uc1 = 1'b1;
    step();
    step();
    step();
    checkEq("t6_pre_rst1", 7'(reset_uc1), 7'(1));
    checkEq("t6_pre_sel", 7'(selected_uc), 7'(1));
    reset = 1'b0;
    err_uc1 = 1'b0;
    step();
    checkEq("t6_outs", outs, 7'(0));
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checkEq($sformatf("t6_after@%0d", k), outs, 7'(0));
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
